// File: rtl/snn_pkg.sv
// Shared types, widths and arithmetic helpers for the spiking-network datapath blocks.
package snn_pkg;

    localparam int WEIGHT_W    = 8;
    localparam int CURRENT_W   = 8;
    localparam int CURRENT_MAX = 127;
    localparam int CURRENT_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

    function automatic logic signed [CURRENT_W-1:0] sat_current(input logic signed [31:0] value);
        if (value > CURRENT_MAX) begin
            return CURRENT_W'(CURRENT_MAX);
        end else if (value < CURRENT_MIN) begin
            return CURRENT_W'(CURRENT_MIN);
        end else begin
            return value[CURRENT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/snn_sat_accumulator.sv
// Signed accumulator with clear/add controls; the saturated view is registered
// together with the sum so both change on the same edge.
module snn_sat_accumulator
    import snn_pkg::*;
#(
    parameter int SUM_W = 13,
    parameter int ADD_W = WEIGHT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_add_en,
    input  logic signed [ADD_W-1:0]     i_addend,
    output logic signed [SUM_W-1:0]     o_sum,
    output logic signed [CURRENT_W-1:0] o_sat
);

    logic signed [SUM_W-1:0]     r_sum;
    logic signed [SUM_W-1:0]     w_sum_nxt;
    logic signed [CURRENT_W-1:0] r_sat;

    // next accumulator value; clear wins over add
    always_comb begin
        w_sum_nxt = r_sum;
        if (i_clear) begin
            w_sum_nxt = {SUM_W{1'b0}};
        end else if (i_add_en) begin
            w_sum_nxt = r_sum + SUM_W'(i_addend);
        end else begin
            w_sum_nxt = r_sum;
        end
    end

    // sum and saturated sum registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= {SUM_W{1'b0}};
            r_sat <= {CURRENT_W{1'b0}};
        end else begin
            r_sum <= w_sum_nxt;
            r_sat <= sat_current(32'(w_sum_nxt));
        end
    end

    assign o_sum = r_sum;
    assign o_sat = r_sat;

endmodule

// File: rtl/snn_current_scheduler.sv
// Walks every neuron's synapses through one weight read port and one accumulator,
// handing each saturated current downstream over a valid/ready handshake.
module snn_current_scheduler
    import snn_pkg::*;
#(
    parameter  int M  = 24,
    parameter  int N  = 8,
    localparam int AW = (clog2(N * M) < 1) ? 1 : clog2(N * M),
    localparam int NW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic [M-1:0]                i_input_spikes,
    output logic                        o_weight_rd_en,
    output logic [AW-1:0]               o_weight_addr,
    input  logic signed [WEIGHT_W-1:0]  i_weight_data,
    output logic signed [CURRENT_W-1:0] o_current_out,
    output logic [NW-1:0]               o_neuron_idx,
    output logic                        o_current_valid,
    input  logic                        i_current_ready,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam int CW    = (clog2(M + 1) < 1) ? 1 : clog2(M + 1);
    localparam int ACC_W = clog2(M * 128) + 1;

    sched_state_t r_state;
    sched_state_t w_state_nxt;
    logic [NW-1:0] r_n;
    logic [NW-1:0] w_n_nxt;
    logic [CW-1:0] r_c;
    logic [CW-1:0] w_c_nxt;
    logic [CW-1:0] w_syn_idx;
    logic [M-1:0]  r_spikes;
    logic          w_latch;
    logic          w_clear;
    logic          w_add_en;
    logic          w_handshake;

    logic          r_rd_en;
    logic [AW-1:0] r_addr;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          w_rd_en_nxt;
    logic [AW-1:0] w_addr_nxt;

    logic signed [ACC_W-1:0]     w_acc_sum_unused;
    logic signed [CURRENT_W-1:0] w_sat;

    assign w_handshake = (r_state == ST_OUT) && i_current_ready;

    // weight for synapse c arrives one cycle after its read, so step c consumes spike c-1
    always_comb begin
        if (r_c == {CW{1'b0}}) begin
            w_syn_idx = {CW{1'b0}};
        end else begin
            w_syn_idx = r_c - CW'(1);
        end
    end

    assign w_add_en = (r_state == ST_ACC) && (r_c != {CW{1'b0}}) && r_spikes[w_syn_idx];

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state plus next counter values
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_c_nxt     = r_c;
        w_latch     = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_ACC;
                    w_n_nxt     = {NW{1'b0}};
                    w_c_nxt     = {CW{1'b0}};
                    w_latch     = 1'b1;
                    w_clear     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (r_c == CW'(M)) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_c_nxt = r_c + CW'(1);
                end
            end
            ST_OUT: begin
                if (w_handshake) begin
                    if (r_n == NW'(N - 1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACC;
                        w_n_nxt     = r_n + NW'(1);
                        w_c_nxt     = {CW{1'b0}};
                        w_clear     = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // counters and the spike vector latched for the whole pass
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n      <= {NW{1'b0}};
            r_c      <= {CW{1'b0}};
            r_spikes <= {M{1'b0}};
        end else begin
            r_n <= w_n_nxt;
            r_c <= w_c_nxt;
            if (w_latch) begin
                r_spikes <= i_input_spikes;
            end
        end
    end

    // outputs are derived from next state so the registered copies line up with the state
    always_comb begin
        w_rd_en_nxt = (w_state_nxt == ST_ACC) && (w_c_nxt != CW'(M));
        if (w_rd_en_nxt) begin
            w_addr_nxt = AW'(w_n_nxt) * AW'(M) + AW'(w_c_nxt);
        end else begin
            w_addr_nxt = {AW{1'b0}};
        end
    end

    // output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_en <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_rd_en <= w_rd_en_nxt;
            r_addr  <= w_addr_nxt;
            r_valid <= (w_state_nxt == ST_OUT);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    snn_sat_accumulator #(
        .SUM_W (ACC_W),
        .ADD_W (WEIGHT_W)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_add_en (w_add_en),
        .i_addend (i_weight_data),
        .o_sum    (w_acc_sum_unused),
        .o_sat    (w_sat)
    );

    assign o_weight_rd_en  = r_rd_en;
    assign o_weight_addr   = r_addr;
    assign o_current_out   = w_sat;
    assign o_neuron_idx    = r_n;
    assign o_current_valid = r_valid;
    assign o_busy          = r_busy;
    assign o_done          = r_done;

endmodule
